mem_arbiter: RTL
================

# mem_arbiter

- Shares the single processor–memory port between the data cache (D-side) and the instruction cache (I-side).
- Grants one request per cycle and records which requester owns each memory tag.
- Routes each returning tag/data beat back to its owner, and drops I-side returns squashed by a rollback.
- Sits between both caches and the memory module. It replaces the direct cache-to-memory wiring and the I-side's snoop of the D-side command.

## Interface

Parameters:
- NUM_TAGS, 16, memory tag space; tag 0 means "no tag".
- AGE_LIMIT, 8, consecutive I-side denials before a forced I grant (used only with aging enabled).

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- rollback  in  1  front-end squash; all in-flight I-side loads become dropped
- d2arb_command  in  2  D-side BUS_NONE/BUS_LOAD/BUS_STORE
- d2arb_addr  in  XLEN  D-side address
- d2arb_data  in  64  D-side store data
- i2arb_command  in  2  I-side BUS_NONE/BUS_LOAD (BUS_STORE is illegal)
- i2arb_addr  in  XLEN  I-side address
- proc2mem_command  out  2  command to memory
- proc2mem_addr  out  XLEN  address to memory
- proc2mem_data  out  64  store data to memory
- mem2proc_response  in  4  memory acceptance tag; 0 means rejected
- mem2proc_data  in  64  returning data
- mem2proc_tag  in  4  returning tag; 0 means none
- arb2d_response  out  4  response forwarded to D-side when D is granted, else 0
- arb2d_data  out  64  mem2proc_data passthrough
- arb2d_tag  out  4  returning tag if owned by D, else 0
- arb2i_response  out  4  response forwarded to I-side when I is granted, else 0
- arb2i_data  out  64  mem2proc_data passthrough
- arb2i_tag  out  4  returning tag if owned by I and not dropped, else 0
- tag_conflict  out  1  sticky error flag: memory issued a tag that is still outstanding

## Operation

Grant (combinational, same cycle):
- Without forced aging, D beats I.
- The granted requester's command, address and data drive proc2mem_*.
- With no request, proc2mem_command = BUS_NONE and addr/data = 0.

Tag table:
- NUM_TAGS entries; entry 0 is never written.
- Fields per entry: valid, owner (0 = D, 1 = I), dropped.
- Allocate when a BUS_LOAD is granted and mem2proc_response != 0: entry[response] ← {1, owner, 0}.
- BUS_STORE grants never allocate.
- Allocating over an entry that is already valid sets tag_conflict; the new owner overwrites the entry.

Return:
- When mem2proc_tag != 0 and entry[mem2proc_tag].valid:
  - owner D → arb2d_tag = mem2proc_tag.
  - owner I and not dropped → arb2i_tag = mem2proc_tag.
  - The entry is cleared at the next clock edge.
- A return to an invalid entry is ignored; both tag outputs stay 0.

Rollback:
- Sets dropped on every valid I-owned entry.
- I-side response is forced to 0 that cycle, even if I is granted.
- If I was granted, the command is still sent; the resulting allocation is stored with dropped = 1.

Simultaneous events, same cycle:
- Retire and allocate of the same tag: allocate wins, entry ends valid with the new owner, no conflict flagged.
- Rollback and an I return: the return is forwarded, because dropped takes effect only from the next edge.

## Timing

- Grant, proc2mem_*, arb2*_response and arb2*_tag are all combinational from the inputs and the current table: zero added latency.
- Table, age counter and tag_conflict update at the clock edge.
- Reset (asynchronous) clears:
  - all table entries, the age counter and tag_conflict;
  - therefore every output is 0 / BUS_NONE while both commands are BUS_NONE.
- Reset mid-flight discards all outstanding tags; later returns carrying those tags are ignored.
- A rejected request (response 0) allocates nothing; the requester holds its command and retries.

## Configuration

MEM_ARB_AGING_EN
- Defined:
  - A 4-bit saturating counter increments each cycle I requests but is not granted.
  - It resets to 0 on any I grant or when I is idle.
  - When the counter ≥ AGE_LIMIT and I requests, I wins over D for that cycle.
- Undefined: strict D-over-I priority and no counter; I may starve indefinitely.

## Structure

- Shared package holds:
  - the BUS_NONE/BUS_LOAD/BUS_STORE encoding (existing);
  - a new MEM_TAG_ENTRY packed struct {valid, owner, dropped};
  - an owner enum ARB_OWNER_D / ARB_OWNER_I.
- One natural sub-module, mem_tag_table: the tag table with allocate, retire and drop ports.
- Grant logic and the aging counter stay in mem_arbiter.

## Test plan

- D LOAD 0x100 and I LOAD 0x200 in the same cycle, response=3 → proc2mem_addr=0x100, arb2d_response=3, arb2i_response=0. Later mem2proc_tag=3 → arb2d_tag=3, arb2i_tag=0.
- I LOAD alone, response=5; three cycles later rollback; then mem2proc_tag=5 → arb2i_tag=0 and entry 5 cleared.
- D STORE, response=7; then mem2proc_tag=7 → no table hit, both tag outputs 0.
- Retire tag 4 and allocate tag 4 to I in the same cycle → tag_conflict stays 0; a later tag=4 return reaches arb2i_tag.
- Aging enabled, AGE_LIMIT=8, D and I requesting continuously → I granted on the 9th cycle, then the counter returns to 0. Aging disabled → I is never granted.
- Assert reset with tags 2 and 6 outstanding, release, then return tag 6 → both tag outputs 0 and tag_conflict=0.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared processor-memory bus encoding plus the types used
// by the D/I memory arbiter and its tag-ownership table.
package mem_arbiter_pkg;

    // Processor address width shared by both caches and the memory port.
    localparam int XLEN  = 32;

    // Width of the memory tag / response field on the bus.
    localparam int TAG_W = 4;

    // Memory bus command encoding (unchanged from the original direct wiring).
    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_command_e;

    // Which cache owns an outstanding memory tag.
    typedef enum logic {
        ARB_OWNER_D = 1'b0,
        ARB_OWNER_I = 1'b1
    } arb_owner_e;

    // One tag-table entry. 'dropped' marks an I-side load squashed by a
    // rollback: its data still comes back from memory but is not forwarded.
    typedef struct packed {
        logic       valid;
        arb_owner_e owner;
        logic       dropped;
    } MEM_TAG_ENTRY;

    localparam MEM_TAG_ENTRY MEM_TAG_ENTRY_EMPTY = '{
        valid:   1'b0,
        owner:   ARB_OWNER_D,
        dropped: 1'b0
    };

    // True when a command is anything other than an idle bus.
    function automatic logic bus_is_request(input logic [1:0] cmd);
        return cmd != BUS_NONE;
    endfunction

endpackage

// File: rtl/mem_tag_table.sv
// mem_tag_table: records which requester owns each outstanding memory tag.
// Entry 0 is the "no tag" encoding and is never written.
// Per-cycle priority on a single entry: allocate > retire > drop.
module mem_tag_table
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS = 16
)
(
    input  logic             clock,
    input  logic             reset,
    // allocation of a newly accepted load
    input  logic             alloc_en,
    input  logic [TAG_W-1:0] alloc_tag,
    input  arb_owner_e       alloc_owner,
    input  logic             alloc_dropped,
    // lookup of the returning tag, and retirement of that same entry
    input  logic [TAG_W-1:0] lookup_tag,
    output MEM_TAG_ENTRY     lookup_entry,
    input  logic             retire_en,
    // rollback: mark every valid I-owned entry as dropped
    input  logic             drop_en,
    // allocation landed on an entry that is still outstanding
    output logic             alloc_conflict
);

    MEM_TAG_ENTRY entry_q [NUM_TAGS];
    MEM_TAG_ENTRY entry_d [NUM_TAGS];

    assign lookup_entry = entry_q[lookup_tag];

    // An entry being retired in the same cycle is free to be reused, so
    // overwriting it is not a conflict.
    assign alloc_conflict = alloc_en
                         && entry_q[alloc_tag].valid
                         && !(retire_en && (lookup_tag == alloc_tag));

    // Next-state for every entry: drop, then retire, then allocate overrides.
    always_comb begin
        entry_d[0] = MEM_TAG_ENTRY_EMPTY;
        for (int i = 1; i < NUM_TAGS; i++) begin
            entry_d[i] = entry_q[i];
            if (drop_en && entry_q[i].valid && (entry_q[i].owner == ARB_OWNER_I)) begin
                entry_d[i].dropped = 1'b1;
            end
            if (retire_en && (lookup_tag == i[TAG_W-1:0])) begin
                entry_d[i] = MEM_TAG_ENTRY_EMPTY;
            end
            if (alloc_en && (alloc_tag == i[TAG_W-1:0])) begin
                entry_d[i] = '{valid: 1'b1, owner: alloc_owner, dropped: alloc_dropped};
            end
        end
    end

    // Table storage; reset discards every outstanding tag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                entry_q[i] <= MEM_TAG_ENTRY_EMPTY;
            end
        end else begin
            for (int i = 0; i < NUM_TAGS; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single processor-memory port between the D-side and
// I-side caches. Grants one requester per cycle (D over I), tracks tag
// ownership in mem_tag_table and steers returning tags to their owner.
// Optional feature macro: MEM_ARB_AGING_EN -- when defined, an I-side
// starvation counter forces an I grant after AGE_LIMIT consecutive denials.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int NUM_TAGS  = 16,
    parameter int AGE_LIMIT = 8
)
(
    input  logic             clock,
    input  logic             reset,
    input  logic             rollback,

    input  logic [1:0]       d2arb_command,
    input  logic [XLEN-1:0]  d2arb_addr,
    input  logic [63:0]      d2arb_data,

    input  logic [1:0]       i2arb_command,
    input  logic [XLEN-1:0]  i2arb_addr,

    output logic [1:0]       proc2mem_command,
    output logic [XLEN-1:0]  proc2mem_addr,
    output logic [63:0]      proc2mem_data,

    input  logic [TAG_W-1:0] mem2proc_response,
    input  logic [63:0]      mem2proc_data,
    input  logic [TAG_W-1:0] mem2proc_tag,

    output logic [TAG_W-1:0] arb2d_response,
    output logic [63:0]      arb2d_data,
    output logic [TAG_W-1:0] arb2d_tag,

    output logic [TAG_W-1:0] arb2i_response,
    output logic [63:0]      arb2i_data,
    output logic [TAG_W-1:0] arb2i_tag,

    output logic             tag_conflict
);

    logic         d_req;
    logic         i_req;
    logic         force_i;
    logic         grant_d;
    logic         grant_i;

    logic         alloc_en;
    arb_owner_e   alloc_owner;
    logic         alloc_dropped;
    logic         alloc_conflict;
    logic         retire_en;
    MEM_TAG_ENTRY ret_entry;

    logic         tag_conflict_q;
    logic         tag_conflict_d;

    assign d_req = bus_is_request(d2arb_command);
    assign i_req = bus_is_request(i2arb_command);

`ifdef MEM_ARB_AGING_EN
    localparam logic [3:0] AGE_MAX = 4'hF;

    logic [3:0] age_q;
    logic [3:0] age_d;

    // An AGE_LIMIT above 15 can never be reached by the 4-bit counter.
    assign force_i = i_req && (int'(age_q) >= AGE_LIMIT);

    // Count consecutive cycles where I is waiting; any I grant or idle I clears it.
    always_comb begin
        age_d = age_q;
        if (!i_req || grant_i) begin
            age_d = 4'd0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + 4'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            age_q <= 4'd0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    // Strict priority: I only wins when D is idle.
    assign force_i = 1'b0;
`endif

    assign grant_i = i_req && (!d_req || force_i);
    assign grant_d = d_req && !grant_i;

    // Drive the memory port from whichever side holds the grant.
    always_comb begin
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        if (grant_d) begin
            proc2mem_command = d2arb_command;
            proc2mem_addr    = d2arb_addr;
            proc2mem_data    = d2arb_data;
        end else if (grant_i) begin
            proc2mem_command = i2arb_command;
            proc2mem_addr    = i2arb_addr;
        end
    end

    // Forward the acceptance tag only to the granted side; a rollback hides
    // it from I even though the command still went out.
    always_comb begin
        arb2d_response = '0;
        arb2i_response = '0;
        if (grant_d) begin
            arb2d_response = mem2proc_response;
        end
        if (grant_i && !rollback) begin
            arb2i_response = mem2proc_response;
        end
    end

    // Only accepted loads get a data return, so only they are tracked.
    assign alloc_en      = (proc2mem_command == BUS_LOAD) && (mem2proc_response != '0);
    assign alloc_owner   = grant_i ? ARB_OWNER_I : ARB_OWNER_D;
    assign alloc_dropped = grant_i && rollback;

    assign retire_en     = (mem2proc_tag != '0) && ret_entry.valid;

    mem_tag_table #(
        .NUM_TAGS (NUM_TAGS)
    ) u_tag_table (
        .clock          (clock),
        .reset          (reset),
        .alloc_en       (alloc_en),
        .alloc_tag      (mem2proc_response),
        .alloc_owner    (alloc_owner),
        .alloc_dropped  (alloc_dropped),
        .lookup_tag     (mem2proc_tag),
        .lookup_entry   (ret_entry),
        .retire_en      (retire_en),
        .drop_en        (rollback),
        .alloc_conflict (alloc_conflict)
    );

    // Steer a returning tag to its owner; dropped I returns and unknown tags vanish.
    always_comb begin
        arb2d_tag = '0;
        arb2i_tag = '0;
        if (retire_en) begin
            if (ret_entry.owner == ARB_OWNER_D) begin
                arb2d_tag = mem2proc_tag;
            end else if (!ret_entry.dropped) begin
                arb2i_tag = mem2proc_tag;
            end
        end
    end

    assign arb2d_data = mem2proc_data;
    assign arb2i_data = mem2proc_data;

    assign tag_conflict_d = tag_conflict_q | alloc_conflict;

    // Sticky conflict flag, cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tag_conflict_q <= 1'b0;
        end else begin
            tag_conflict_q <= tag_conflict_d;
        end
    end

    assign tag_conflict = tag_conflict_q;

endmodule
